irq_defer: RTL and testbench
============================

Name: irq_defer

Overview:
- Interrupt-side counterpart to the violation monitor.
- Sits between the peripheral interrupt lines and the CPU IRQ inputs.
- While pc executes inside secure memory (SMEM), every interrupt is held back and latched as pending. Pending interrupts are delivered only after pc has left SMEM and stayed outside for a guard window.
- An optional watchdog flags interrupts that stay deferred for too long.

Parameters:
- SMEM_BASE, 16'hE000, first address of secure memory.
- SMEM_SIZE, 16'h1000, secure memory size in bytes.
- NIRQ, 14, number of interrupt lines.
- EXIT_GUARD, 2, consecutive cycles pc must be outside SMEM before release (range 1..15).
- MAX_DEFER, 16'd4096, cycles of deferral before defer_timeout asserts.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pc  in  16  current CPU program counter
- irq_in  in  NIRQ  level interrupt requests from peripherals
- irq_acc  in  NIRQ  CPU interrupt acknowledge, one-cycle pulse per line
- irq_out  out  NIRQ  gated interrupt requests to CPU, registered
- irq_pending  out  1  OR of the pending register, registered
- defer_timeout  out  1  sticky deferral-watchdog flag

Behaviour:
- LAST_SMEM_ADDR = SMEM_BASE + SMEM_SIZE - 2.
- in_smem = (pc >= SMEM_BASE) && (pc <= LAST_SMEM_ADDR). Combinational, from the current pc.
- States (2-bit):
  - OPEN: pass-through.
  - HOLD: pc is in SMEM.
  - GUARD: pc has left SMEM and the guard window is counting.
- Reset (reset_n low, async): state = OPEN; pend = 0; guard_cnt = 0; defer_cnt = 0; irq_out = 0; irq_pending = 0; defer_timeout = 0.
- Transitions:
  - OPEN, in_smem → HOLD.
  - HOLD, !in_smem → GUARD, guard_cnt = 1.
  - HOLD, in_smem → stay in HOLD.
  - GUARD, in_smem → HOLD, guard_cnt = 0.
  - GUARD, !in_smem, guard_cnt == EXIT_GUARD → OPEN, guard_cnt = 0.
  - GUARD, otherwise → guard_cnt + 1.
- Gating condition: gate = (state != OPEN) || in_smem. This blocks delivery in the same cycle pc first enters SMEM, with no one-cycle leak.
- Pending register pend[NIRQ]:
  - If gate: pend <= pend | irq_in.
  - irq_acc clears the corresponding bits.
  - If capture and clear hit the same bit in the same cycle, capture wins.
- irq_out next value:
  - If gate: 0.
  - Otherwise: (irq_in | pend) & ~irq_acc.
  - Latency in OPEN is 1 cycle from irq_in to irq_out.
  - On the OPEN transition from GUARD, pending interrupts appear on irq_out one cycle after state becomes OPEN.
- irq_pending next value = |pend_next.
- Pending bits persist across any number of HOLD/GUARD cycles. They are cleared only by irq_acc or by reset.
- irq_acc arriving while gate is true still clears pend. This is a CPU protocol error and is tolerated.
- Reset asserted mid-HOLD drops all pending interrupts. Pending state is never preserved across reset.
- pc wrap/edges:
  - pc = SMEM_BASE-1 and pc = LAST_SMEM_ADDR+1 are outside SMEM.
  - pc = SMEM_BASE and pc = LAST_SMEM_ADDR are inside.

Optional Feature:
- Macro: IRQ_DEFER_TIMEOUT_EN.
- Defined:
  - defer_cnt (16-bit) increments each cycle where state != OPEN and pend != 0, saturating at MAX_DEFER.
  - defer_cnt resets to 0 on entering OPEN.
  - defer_timeout is set when defer_cnt == MAX_DEFER and stays high until reset_n.
- Undefined: no counter is instantiated, and defer_timeout is tied to 0.

Decomposition:
- Shared package holds:
  - SMEM_BASE/SMEM_SIZE defaults and the LAST_SMEM_ADDR derivation, shared with the violation monitor.
  - State encoding constants: OPEN = 2'd0, HOLD = 2'd1, GUARD = 2'd2.
- One natural sub-module, smem_range_cmp: pc → in_smem. It is reusable by other monitors.
- Everything else stays flat in irq_defer.

Test Plan:
- Passthrough: pc = 16'hC000, irq_in[3] raised → irq_out[3] = 1 the next cycle; irq_acc[3] pulse → irq_out[3] = 0 the next cycle, irq_pending = 0.
- Deferral: pc = 16'hE010, irq_in[5] pulsed for 1 cycle → irq_out stays 0, irq_pending = 1 the next cycle.
- Deferral release: continue from the deferral case with pc = 16'hC000 and EXIT_GUARD = 2 → irq_out[5] = 1 exactly 4 cycles after pc leaves SMEM (1 HOLD→GUARD, 2 guard, 1 register).
- Guard abort: pc exits for 1 cycle, then pc = 16'hE100 → state back to HOLD, irq_out stays 0, pend retained.
- Boundaries: pc = 16'hDFFE and 16'hF000 → no gating; pc = 16'hE000 and 16'hEFFE → gating. irq_in raised in the first in-SMEM cycle never reaches irq_out.
- Timeout (IRQ_DEFER_TIMEOUT_EN, MAX_DEFER = 16): pend ≠ 0 in HOLD for 16 cycles → defer_timeout = 1 and stays 1 after exit. reset_n low → all outputs 0 asynchronously.

Source files
------------

// File: rtl/irq_defer_pkg.sv
// irq_defer_pkg: secure-memory window defaults and irq_defer state encoding,
// shared with the violation monitor.
package irq_defer_pkg;

    localparam logic [15:0] SMEM_BASE_DEF = 16'hE000;
    localparam logic [15:0] SMEM_SIZE_DEF = 16'h1000;

    typedef enum logic [1:0] {
        OPEN  = 2'd0,
        HOLD  = 2'd1,
        GUARD = 2'd2
    } state_t;

    // The last word-aligned address inside SMEM.
    function automatic logic [15:0] last_smem_addr(input logic [15:0] base, input logic [15:0] size);
        return base + size - 16'd2;
    endfunction

endpackage

// File: rtl/irq_defer_smem_range_cmp.sv
// smem_range_cmp: flags a pc that lies inside the secure memory window [BASE, LAST].
module smem_range_cmp
    import irq_defer_pkg::*;
#(
    parameter logic [15:0] BASE = SMEM_BASE_DEF,
    parameter logic [15:0] LAST = last_smem_addr(SMEM_BASE_DEF, SMEM_SIZE_DEF)
) (
    input  logic [15:0] pc,
    output logic        in_smem
);

    assign in_smem = (pc >= BASE) && (pc <= LAST);

endmodule

// File: rtl/irq_defer.sv
// irq_defer: holds interrupts back while pc is in SMEM and releases them after a guard window.
// Optional deferral watchdog enabled by defining IRQ_DEFER_TIMEOUT_EN.
module irq_defer
    import irq_defer_pkg::*;
#(
    parameter logic [15:0] SMEM_BASE  = SMEM_BASE_DEF,
    parameter logic [15:0] SMEM_SIZE  = SMEM_SIZE_DEF,
    parameter int          NIRQ       = 14,
    parameter int          EXIT_GUARD = 2,
    parameter logic [15:0] MAX_DEFER  = 16'd4096
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [15:0]     pc,
    input  logic [NIRQ-1:0] irq_in,
    input  logic [NIRQ-1:0] irq_acc,
    output logic [NIRQ-1:0] irq_out,
    output logic            irq_pending,
    output logic            defer_timeout
);

    if (EXIT_GUARD < 1 || EXIT_GUARD > 15 || MAX_DEFER == 16'd0) begin : g_bad_cfg
        $error("irq_defer: EXIT_GUARD must be 1..15 and MAX_DEFER nonzero");
    end

    state_t          state;
    logic [3:0]      guard_cnt;
    logic [NIRQ-1:0] pend;
    logic [NIRQ-1:0] pend_next;
    logic            in_smem;
    logic            gate;
    logic            leave;

    smem_range_cmp #(
        .BASE(SMEM_BASE),
        .LAST(last_smem_addr(SMEM_BASE, SMEM_SIZE))
    ) u_range (
        .pc     (pc),
        .in_smem(in_smem)
    );

    // Gating also looks at the live pc so the first in-SMEM cycle cannot leak.
    assign gate      = (state != OPEN) || in_smem;
    assign leave     = (state == GUARD) && !in_smem && (guard_cnt == 4'(EXIT_GUARD));
    assign pend_next = (pend & ~irq_acc) | (gate ? irq_in : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= OPEN;
            guard_cnt   <= '0;
            pend        <= '0;
            irq_out     <= '0;
            irq_pending <= 1'b0;
        end else begin
            pend        <= pend_next;
            irq_pending <= |pend_next;
            irq_out     <= gate ? '0 : (irq_in | pend) & ~irq_acc;
            case (state)
                OPEN: if (in_smem) state <= HOLD;
                HOLD: if (!in_smem) begin
                    state     <= GUARD;
                    guard_cnt <= 4'd1;
                end
                GUARD: if (in_smem) begin
                    state     <= HOLD;
                    guard_cnt <= '0;
                end else if (leave) begin
                    state     <= OPEN;
                    guard_cnt <= '0;
                end else begin
                    guard_cnt <= guard_cnt + 4'd1;
                end
                default: begin
                    state     <= OPEN;
                    guard_cnt <= '0;
                end
            endcase
        end
    end

`ifdef IRQ_DEFER_TIMEOUT_EN
    logic [15:0] defer_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            defer_cnt     <= '0;
            defer_timeout <= 1'b0;
        end else begin
            defer_cnt <= leave ? '0 :
                         (state != OPEN && |pend && defer_cnt != MAX_DEFER) ? defer_cnt + 16'd1 :
                         defer_cnt;
            if (defer_cnt == MAX_DEFER) defer_timeout <= 1'b1;
        end
    end
`else
    assign defer_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_irq_defer.sv
// tb_irq_defer: directed vectors for irq_defer; expectations are queued per cycle
// and a negedge monitor pops and compares them against the registered outputs.
module tb_irq_defer;

    typedef struct {
        int          due;
        logic [13:0] out;
        logic        pend;
        logic        to;
        string       name;
    } exp_t;

`ifdef IRQ_DEFER_TIMEOUT_EN
    localparam int TO_AT = 18;
`else
    localparam int TO_AT = 100000;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc;
    logic [13:0] irq_in;
    logic [13:0] irq_acc;
    logic [13:0] irq_out;
    logic        irq_pending;
    logic        defer_timeout;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q[$];

    irq_defer #(.MAX_DEFER(16'd16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc           (pc),
        .irq_in       (irq_in),
        .irq_acc      (irq_acc),
        .irq_out      (irq_out),
        .irq_pending  (irq_pending),
        .defer_timeout(defer_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({irq_out, irq_pending, defer_timeout} !== {e.out, e.pend, e.to}) begin
                failures++;
                $display("FAIL %s: irq_out=%h irq_pending=%b defer_timeout=%b, expected %h %b %b",
                         e.name, irq_out, irq_pending, defer_timeout, e.out, e.pend, e.to);
            end
        end
    end

    task automatic step(input logic [15:0] p, input logic [13:0] i, input logic [13:0] a,
                        input logic [13:0] eo, input logic ep, input logic et, input string nm);
        exp_t e;
        pc = p;
        irq_in = i;
        irq_acc = a;
        e.due = cyc + 1;
        e.out = eo;
        e.pend = ep;
        e.to = et;
        e.name = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        pc = 16'hC000;
        irq_in = '0;
        irq_acc = '0;
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 0, 0, "reset0");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 0, 0, "reset1");
        reset_n = 1'b1;
        // passthrough
        step(16'hC000, 14'h0008, 14'h0000, 14'h0008, 0, 0, "pass_irq3");
        step(16'hC000, 14'h0000, 14'h0008, 14'h0000, 0, 0, "pass_acc3");
        step(16'hC000, 14'h2001, 14'h0000, 14'h2001, 0, 0, "pass_multi");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 0, 0, "pass_idle");
        // deferral and release after the guard window
        step(16'hE010, 14'h0020, 14'h0000, 14'h0000, 1, 0, "defer_capture");
        step(16'hE010, 14'h0000, 14'h0000, 14'h0000, 1, 0, "defer_hold");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 1, 0, "rel_guard1");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 1, 0, "rel_guard2");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 1, 0, "rel_open");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0020, 1, 0, "rel_deliver");
        step(16'hC000, 14'h0000, 14'h0020, 14'h0000, 0, 0, "rel_acc");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 0, 0, "rel_idle");
        // guard abort, capture-beats-clear
        step(16'hE010, 14'h0080, 14'h0000, 14'h0000, 1, 0, "abort_capture");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 1, 0, "abort_exit1");
        step(16'hE100, 14'h0000, 14'h0000, 14'h0000, 1, 0, "abort_reenter");
        step(16'hE100, 14'h0080, 14'h0080, 14'h0000, 1, 0, "capture_wins");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 1, 0, "abort_guard1");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 1, 0, "abort_guard2");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 1, 0, "abort_open");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0080, 1, 0, "abort_deliver");
        step(16'hC000, 14'h0000, 14'h0080, 14'h0000, 0, 0, "abort_acc");
        // SMEM boundaries
        step(16'hDFFE, 14'h0001, 14'h0000, 14'h0001, 0, 0, "edge_dffe");
        step(16'hDFFF, 14'h0004, 14'h0000, 14'h0004, 0, 0, "edge_dfff");
        step(16'hEFFF, 14'h0008, 14'h0000, 14'h0008, 0, 0, "edge_efff");
        step(16'hF000, 14'h0002, 14'h0000, 14'h0002, 0, 0, "edge_f000");
        step(16'hE000, 14'h0100, 14'h0000, 14'h0000, 1, 0, "edge_e000_first");
        step(16'hEFFE, 14'h0000, 14'h0000, 14'h0000, 1, 0, "edge_effe_hold");
        step(16'hEFFE, 14'h0000, 14'h0100, 14'h0000, 0, 0, "acc_while_gated");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 0, 0, "edge_guard1");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 0, 0, "edge_guard2");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 0, 0, "edge_open");
        step(16'hEFFE, 14'h0200, 14'h0000, 14'h0000, 1, 0, "edge_effe_first");
        step(16'hEFFE, 14'h0000, 14'h0200, 14'h0000, 0, 0, "edge_effe_acc");
        // async reset mid-HOLD drops pending state
        step(16'hE010, 14'h0400, 14'h0000, 14'h0000, 1, 0, "rst_hold_pend");
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({irq_out, irq_pending, defer_timeout} !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset: irq_out=%h irq_pending=%b defer_timeout=%b, expected all 0",
                     irq_out, irq_pending, defer_timeout);
        end
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 0, 0, "rst_low");
        reset_n = 1'b1;
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 0, 0, "rst_dropped");
        // long deferral: watchdog fires only when the timeout feature is built in
        for (int k = 1; k <= 20; k++)
            step(16'hE010, (k == 1) ? 14'h0001 : 14'h0000, 14'h0000, 14'h0000, 1, k >= TO_AT,
                 $sformatf("long_hold%0d", k));
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 1, 21 >= TO_AT, "long_guard1");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 1, 22 >= TO_AT, "long_guard2");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0000, 1, 23 >= TO_AT, "long_open");
        step(16'hC000, 14'h0000, 14'h0000, 14'h0001, 1, 24 >= TO_AT, "long_deliver");
        step(16'hC000, 14'h0000, 14'h0001, 14'h0000, 0, 25 >= TO_AT, "long_acc");
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
